i2c_cmd_queue: RTL and testbench

- Command scheduler that sits directly upstream of i2c_mock_master.
- Buffers host I2C commands (read/write, 7-bit address, data) in a command FIFO and issues them one at a time on the master's start/write/address/write_data interface.
- Tracks completion via the master's ready/error outputs and pushes one response (read data, ack error, timeout) per command into a response FIFO for the host.

---
 rtl/i2c_cmd_queue.sv | 190 +++++++++++++++++++
 tb/tb_i2c_cmd_queue.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_queue.sv
// I2C command queue: buffers host commands, issues them one at a time
// to the mock master and returns one response per command.
module i2c_cmd_queue #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [6:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       m_start,
  output logic       m_write,
  output logic [6:0] m_address,
  output logic [7:0] m_write_data,
  input  logic       m_ready,
  input  logic       m_error,
  input  logic [7:0] m_read_data
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t r_state;

  logic [15:0]   r_cmd_mem [CMD_DEPTH];
  logic [CAW:0]  r_cwr;
  logic [CAW:0]  r_crd;
  logic [17:0]   r_rsp_mem [RSP_DEPTH];
  logic [RAW:0]  r_rwr;
  logic [RAW:0]  r_rrd;

  logic [TW-1:0] r_timer;
  logic          r_m_start;
  logic          r_m_write;
  logic [6:0]    r_m_address;
  logic [7:0]    r_m_wdata;
  logic [7:0]    r_rdata;
  logic          r_err;
  logic          r_to;

  logic          w_cmd_empty;
  logic          w_cmd_full;
  logic          w_cmd_push;
  logic          w_cmd_pop;
  logic [15:0]   w_cmd_head;
  logic          w_rsp_empty;
  logic          w_rsp_full;
  logic          w_rsp_push;
  logic          w_rsp_pop;
  logic [17:0]   w_rsp_head;
  logic          w_tmo;

  assign w_cmd_empty = (r_cwr == r_crd);
  assign w_cmd_full  = (r_cwr[CAW] != r_crd[CAW]) &&
                       (r_cwr[CAW-1:0] == r_crd[CAW-1:0]);
  assign w_cmd_head  = r_cmd_mem[r_crd[CAW-1:0]];
  assign w_cmd_pop   = (r_state == S_IDLE) && !w_cmd_empty && m_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept
  assign cmd_ready   = !w_cmd_full || w_cmd_pop;
  assign w_cmd_push  = cmd_valid && cmd_ready;

  assign w_rsp_empty = (r_rwr == r_rrd);
  assign w_rsp_full  = (r_rwr[RAW] != r_rrd[RAW]) &&
                       (r_rwr[RAW-1:0] == r_rrd[RAW-1:0]);
  assign w_rsp_head  = r_rsp_mem[r_rrd[RAW-1:0]];
  assign w_rsp_push  = (r_state == S_RESP) && !w_rsp_full;
  assign w_rsp_pop   = rsp_valid && rsp_ready;

  assign rsp_valid = !w_rsp_empty;
  assign {rsp_write, rsp_addr, rsp_data, rsp_error, rsp_timeout} =
    rsp_valid ? w_rsp_head : 18'd0;

  assign busy         = (r_state != S_IDLE) || !w_cmd_empty;
  assign m_start      = r_m_start;
  assign m_write      = r_m_write;
  assign m_address    = r_m_address;
  assign m_write_data = r_m_wdata;
  assign w_tmo        = (r_timer == TW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (w_cmd_push)
      r_cmd_mem[r_cwr[CAW-1:0]] <= {cmd_write, cmd_addr, cmd_data};
  end

  always_ff @(posedge clock) begin
    if (w_rsp_push)
      r_rsp_mem[r_rwr[RAW-1:0]] <=
        {r_m_write, r_m_address, r_rdata, r_err, r_to};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cwr <= '0;
      r_crd <= '0;
      r_rwr <= '0;
      r_rrd <= '0;
    end else begin
      if (w_cmd_push) r_cwr <= r_cwr + 1'b1;
      if (w_cmd_pop)  r_crd <= r_crd + 1'b1;
      if (w_rsp_push) r_rwr <= r_rwr + 1'b1;
      if (w_rsp_pop)  r_rrd <= r_rrd + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_m_start   <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_address <= 7'd0;
      r_m_wdata   <= 8'd0;
      r_rdata     <= 8'd0;
      r_err       <= 1'b0;
      r_to        <= 1'b0;
    end else begin
      r_m_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_pop) begin
            r_m_write   <= w_cmd_head[15];
            r_m_address <= w_cmd_head[14:8];
            r_m_wdata   <= w_cmd_head[7:0];
            r_m_start   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // m_ready falling beats an expiring timer
          if (!m_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b0;
            r_to    <= 1'b1;
            r_rdata <= 8'd0;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (m_ready) begin
            r_err   <= m_error;
            r_to    <= 1'b0;
            r_rdata <= r_m_write ? r_m_wdata : m_read_data;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b0;
            r_to    <= 1'b1;
            r_rdata <= 8'd0;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (!w_rsp_full) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: mock master with slaves at 80..83,
// reference model of responses and a decoupled response scoreboard.
module tb_i2c_cmd_queue;

  localparam int TMO  = 16;
  localparam logic [6:0] DEAD = 7'd100;
  localparam logic [6:0] HANG = 7'd101;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic       rsp_timeout;
  logic       busy;
  logic       m_start;
  logic       m_write;
  logic [6:0] m_address;
  logic [7:0] m_write_data;
  logic       m_ready;
  logic       m_error;
  logic [7:0] m_read_data;

  i2c_cmd_queue #(
    .CMD_DEPTH(4),
    .RSP_DEPTH(4),
    .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_addr(rsp_addr),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .m_start(m_start),
    .m_write(m_write),
    .m_address(m_address),
    .m_write_data(m_write_data),
    .m_ready(m_ready),
    .m_error(m_error),
    .m_read_data(m_read_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int rr_mode  = 0;

  logic [15:0] exp_iss [$];
  logic [17:0] exp_rsp [$];
  logic [7:0]  mmem [128];
  logic [7:0]  smem [128];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 4; i++) mmem[80+i] = 8'h10 + 8'(i);
  endtask

  task automatic stub_init();
    for (int i = 0; i < 4; i++) smem[80+i] = 8'h10 + 8'(i);
  endtask

  // Expected response from the command's meaning alone
  function automatic logic [17:0] model(input logic w, input logic [6:0] a,
                                        input logic [7:0] d);
    logic [17:0] r;
    if (a == DEAD || a == HANG) begin
      r = {w, a, 8'h00, 2'b01};
    end else if (a >= 7'd80 && a <= 7'd83) begin
      if (w) begin
        mmem[a] = d;
        r = {1'b1, a, d, 2'b00};
      end else begin
        r = {1'b0, a, mmem[a], 2'b00};
      end
    end else begin
      r = {w, a, (w ? d : 8'hFF), 2'b10};
    end
    return r;
  endfunction

  // Mock master with slave memories
  initial begin
    int st;
    int cnt;
    logic sw;
    logic [6:0] sa;
    logic [7:0] sd;
    logic [15:0] e;
    logic ex;
    st = 0;
    cnt = 0;
    sw = 1'b0;
    sa = 7'd0;
    sd = 8'd0;
    m_ready = 1'b1;
    m_error = 1'b0;
    m_read_data = 8'd0;
    stub_init();
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        st = 0;
        m_ready = 1'b1;
        m_error = 1'b0;
        m_read_data = 8'd0;
        stub_init();
      end else begin
        if (m_start) begin
          n_starts++;
          chk("start_overlap", 32'(st), 32'd0);
          if (exp_iss.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_start: addr %0d", m_address);
          end else begin
            e = exp_iss.pop_front();
            chk("issue_cmd", 32'({m_write, m_address}), 32'(e[15:8]));
            if (e[15]) chk("issue_data", 32'(m_write_data), 32'(e[7:0]));
          end
        end
        case (st)
          0: begin
            if (m_start && m_address != DEAD) begin
              sw = m_write;
              sa = m_address;
              sd = m_write_data;
              cnt = $urandom_range(1, 3);
              st = 1;
            end
          end
          1: begin
            chk("hold_addr", 32'({m_write, m_address}), 32'({sw, sa}));
            cnt--;
            if (cnt == 0) begin
              m_ready = 1'b0;
              cnt = (sa == HANG) ? TMO + 6 : $urandom_range(1, 5);
              st = 2;
            end
          end
          default: begin
            chk("hold_addr", 32'({m_write, m_address}), 32'({sw, sa}));
            cnt--;
            if (cnt == 0) begin
              ex = (sa >= 7'd80 && sa <= 7'd83);
              if (ex && sw) smem[sa] = sd;
              m_error = !ex;
              m_read_data = (ex && !sw) ? smem[sa] : 8'hFF;
              m_ready = 1'b1;
              st = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #3;
      case (rr_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Response monitor
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clock);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %0h",
                   {rsp_write, rsp_addr, rsp_data, rsp_error, rsp_timeout});
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp", 32'({rsp_write, rsp_addr, rsp_data, rsp_error,
                          rsp_timeout}), 32'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic w, input logic [6:0] a,
                      input logic [7:0] d, output logic first_try);
    int k;
    logic acc;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    acc = 1'b0;
    k = 0;
    first_try = 1'b0;
    while (!acc && k < 500) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = 1'b1;
        first_try = (k == 0);
      end
      @(posedge clock);
      k++;
    end
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      exp_iss.push_back({w, a, d});
      exp_rsp.push_back(model(w, a, d));
    end
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 2000 && (busy || rsp_valid || !m_ready ||
                        exp_rsp.size() != 0)) begin
      tick();
      k++;
    end
    chk("drain_in_time", 32'(k < 2000), 32'd1);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    chk("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
  endtask

  function automatic logic [6:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return 7'd80 + 7'(r % 4);
    if (r < 17) return 7'd90;
    if (r == 17) return DEAD;
    if (r == 18) return HANG;
    return 7'd91;
  endfunction

  logic ft;
  int   n;
  int   k;
  int   s0;
  int   rc;
  logic dn;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 7'd0;
    cmd_data = 8'd0;
    model_init();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_outs", 32'({m_start, m_write, m_address, m_write_data}), 32'd0);
    chk("rst_rsp_outs", 32'({rsp_write, rsp_addr, rsp_data, rsp_error,
                             rsp_timeout}), 32'd0);
    #1;
    reset = 1'b0;
    tick();

    push(1'b1, 7'd80, 8'h21, ft);
    wait_idle();

    push(1'b1, 7'd80, 8'h21, ft);
    chk("b2b_ready0", 32'(ft), 32'd1);
    push(1'b1, 7'd81, 8'h56, ft);
    chk("b2b_ready1", 32'(ft), 32'd1);
    push(1'b1, 7'd82, 8'h18, ft);
    chk("b2b_ready2", 32'(ft), 32'd1);
    push(1'b0, 7'd83, 8'h00, ft);
    chk("b2b_ready3", 32'(ft), 32'd1);
    wait_idle();
    push(1'b0, 7'd80, 8'h00, ft);
    wait_idle();

    push(1'b1, 7'd90, 8'h44, ft);
    push(1'b0, 7'd81, 8'h00, ft);
    wait_idle();

    push(1'b0, DEAD, 8'h5A, ft);
    n = -1;
    k = 0;
    dn = 1'b0;
    while (!dn && k < 200) begin
      @(negedge clock);
      if (n >= 0) n++;
      else if (m_start) n = 0;
      if (n >= 0 && rsp_valid) dn = 1'b1;
      k++;
    end
    chk("timeout_latency", 32'(n), 32'(TMO + 3));
    tick();
    wait_idle();

    push(1'b1, HANG, 8'h66, ft);
    push(1'b0, 7'd82, 8'h00, ft);
    wait_idle();

    rr_mode = 2;
    tick();
    for (int i = 0; i < 9; i++)
      push($urandom_range(0, 1) != 0, 7'd80 + 7'($urandom_range(0, 3)),
           8'($urandom), ft);
    repeat (40) tick();
    chk("bp_cmd_full", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    s0 = n_starts;
    rc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_ready) rc++;
    end
    chk("bp_no_start", 32'(n_starts - s0), 32'd0);
    chk("bp_ready_low", 32'(rc), 32'd0);
    rr_mode = 0;
    push(1'b0, 7'd81, 8'h00, ft);
    wait_idle();

    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, 1) != 0, rand_addr(), 8'($urandom), ft);
      repeat ($urandom_range(0, 3)) tick();
    end
    rr_mode = 0;
    wait_idle();

    push(1'b1, HANG, 8'h01, ft);
    push(1'b1, 7'd80, 8'h77, ft);
    push(1'b0, 7'd81, 8'h00, ft);
    k = 0;
    while (m_ready && k < 100) begin
      tick();
      k++;
    end
    chk("reach_wait_done", 32'(m_ready), 32'd0);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_m_outs", 32'({m_start, m_write, m_address, m_write_data}),
        32'd0);
    exp_iss.delete();
    exp_rsp.delete();
    model_init();
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    rc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid || busy) rc++;
    end
    chk("no_rsp_after_rst", 32'(rc), 32'd0);
    push(1'b0, 7'd80, 8'h00, ft);
    push(1'b0, 7'd81, 8'h00, ft);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
